op_burst_decoder: RTL
=====================

# op_burst_decoder

Parametrised, handshaked successor to the single-cycle opcode decoder. Accepts one command (opcode plus beat count) on a valid/ready input, decodes it into `write`/`source` controls, and replays those controls for a programmable number of beats on a valid/ready output with a `last` marker. Illegal opcodes are consumed without producing beats and are reported through a sticky error flag. It sits between the command fetch stage and the datapath write/read muxing.

## Interface
Parameters:
- `OP_W`, 4: opcode width; must be ≥ 4.
- `SRC_W`, 2: source select width; must be ≥ 2.
- `LEN_W`, 3: beat-count field width; a burst is `op_len+1` beats (1..2^LEN_W).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  command present.
- `in_ready`  out  1  command accepted when `in_valid && in_ready` at a rising edge.
- `op_code`  in  OP_W  opcode.
- `op_len`  in  LEN_W  beats minus one.
- `out_valid`  out  1  beat present.
- `out_ready`  in  1  beat consumed when `out_valid && out_ready` at a rising edge.
- `write`  out  1  decoded write enable, constant for the whole burst.
- `source`  out  SRC_W  decoded source select, zero-extended, constant for the whole burst.
- `last`  out  1  high on the final beat of a burst.
- `err_illegal`  out  1  sticky illegal-opcode flag.
- `err_clr`  in  1  synchronous clear of `err_illegal` (and of `err_cnt` when present).

## Operation
- Decode (upper `OP_W-4` bits must be zero, otherwise the opcode is illegal):
  - 4'b0001 (WRITE_A): write=1, source=0.
  - 4'b0010 (WRITE_B): write=1, source=2.
  - 4'b1011 (READ_C): write=0, source=3.
  - Anything else: illegal. No X is ever driven.
- FSM states:
  - IDLE: `out_valid`=0.
    - Legal accept → BURST with `cnt`=`op_len`, controls latched.
    - Illegal accept → stay IDLE and set `err_illegal`.
  - BURST: `out_valid`=1 and `last`=(`cnt`==0).
    - Handshake with `cnt`>0 → `cnt`-1.
    - Handshake with `last` → IDLE, or directly into the next command if one is accepted in the same cycle.
- `in_ready` = (state==IDLE) || (`out_valid && out_ready && last`). This is combinational from state and `out_ready`; there is no path from `in_valid` to `in_ready`.
- Output stability: while `out_valid && !out_ready`, `write`/`source`/`last` hold.
- `err_illegal`: set on illegal accept; cleared by `err_clr`. If both occur in the same cycle, set wins.
- `cnt` is LEN_W bits wide; `op_len`=all-ones gives 2^LEN_W beats with no wrap.

## Timing
- Reset values: `out_valid`=0, `write`=0, `source`=0, `last`=0, `err_illegal`=0, state=IDLE, `cnt`=0. `in_ready` is 1 after reset.
- Latency: command accepted at edge t → first beat valid in the cycle after t.
- Throughput: one beat per cycle under continuous `out_ready`. There are zero bubble cycles between consecutive legal bursts.
- An illegal command takes one accept cycle. `in_ready` stays high, so back-to-back illegal commands are accepted every cycle.
- `err_illegal` is visible the cycle after the illegal accept.
- Reset asserted mid-burst: outputs return immediately (asynchronously) to reset values and the remaining beats are dropped.

## Configuration
- `OP_BURST_ERR_CNT_EN` defined: adds output port `err_cnt` (8 bits).
  - Increments on each illegal accept and saturates at 255.
  - Cleared to 0 by `err_clr`; increment wins over a same-cycle clear, giving a value of 1.
  - Reset value 0.
- Undefined: the port and the counter are absent, and all other behaviour is identical.

## Test plan
- Reset, then WRITE_A with `op_len`=0 and `out_ready`=1 → exactly one beat: write=1, source=0, last=1. Then `out_valid`=0.
- READ_C with `op_len`=3, `out_ready` toggling 1,0,1,1,0,1 → four beats total, each with write=0 and source=3. `last` appears on the 4th beat only, and outputs hold during stalls.
- WRITE_B (`op_len`=1) with READ_C (`op_len`=0) presented immediately behind it → beats B,B(last),C(last) on three consecutive cycles, with `in_ready` high on the B-last cycle.
- `op_code`=4'b0101 → no beat. `err_illegal`=1 from the next cycle. `err_clr` pulse → 0. Illegal accept and `err_clr` in the same cycle → stays 1.
- `rst_n` dropped mid-burst (`op_len`=7, after 3 beats) → `out_valid`=0 asynchronously. After release, a new WRITE_A is decoded correctly.
- With `OP_BURST_ERR_CNT_EN` defined: 300 consecutive illegal commands → `err_cnt`=255, then `err_clr` → 0. With `OP_W`=6, opcode 6'b010001 → illegal.

Source files
------------

// File: rtl/op_burst_decoder.sv
// Handshaked opcode decoder that replays write/source controls for op_len+1 beats.
// Define OP_BURST_ERR_CNT_EN to add the saturating 8-bit err_cnt output.
module op_burst_decoder #(
   parameter int OP_W  = 4,
   parameter int SRC_W = 2,
   parameter int LEN_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op_code,
   input  logic [LEN_W-1:0] op_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             write,
   output logic [SRC_W-1:0] source,
   output logic             last,
   output logic             err_illegal,
   input  logic             err_clr
`ifdef OP_BURST_ERR_CNT_EN
   ,
   output logic [7:0]       err_cnt
`endif
);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   cnt_q, cnt_d;
   logic               write_q, write_d;
   logic [SRC_W-1:0]   source_q, source_d;
   logic               err_q, err_d;

   logic               legal;
   logic               dec_write;
   logic [SRC_W-1:0]   dec_source;
   logic               beat_hs;
   logic               accept;
   logic               illegal_acc;

   // Any nonzero bit above the 4-bit opcode field makes the command illegal.
   always_comb begin
      legal      = 1'b0;
      dec_write  = 1'b0;
      dec_source = '0;
      if ((op_code >> 4) == '0) begin
         case (op_code[3:0])
            4'b0001: begin
               legal      = 1'b1;
               dec_write  = 1'b1;
               dec_source = '0;
            end
            4'b0010: begin
               legal      = 1'b1;
               dec_write  = 1'b1;
               dec_source = SRC_W'(2'd2);
            end
            4'b1011: begin
               legal      = 1'b1;
               dec_write  = 1'b0;
               dec_source = SRC_W'(2'd3);
            end
            default: begin
               legal      = 1'b0;
               dec_write  = 1'b0;
               dec_source = '0;
            end
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      write_d     = write_q;
      source_d    = source_q;
      err_d       = err_q;
      out_valid   = (state_q == BURST);
      last        = out_valid && (cnt_q == '0);
      beat_hs     = out_valid && out_ready;
      in_ready    = (state_q == IDLE) || (beat_hs && last);
      accept      = in_valid && in_ready;
      illegal_acc = accept && !legal;

      if (beat_hs) begin
         if (last) begin
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q - LEN_W'(1);
         end
      end
      // A command taken on the final beat chains straight into the next burst.
      if (accept && legal) begin
         state_d  = BURST;
         cnt_d    = op_len;
         write_d  = dec_write;
         source_d = dec_source;
      end
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (illegal_acc) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         write_q  <= 1'b0;
         source_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         source_q <= source_d;
         err_q    <= err_d;
      end
   end

   assign write       = write_q;
   assign source      = source_q;
   assign err_illegal = err_q;

`ifdef OP_BURST_ERR_CNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = 8'd0;
      end
      if (illegal_acc) begin
         err_cnt_d = (err_clr) ? 8'd1 :
                     (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= 8'd0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`endif

endmodule
